// File: rtl/request_encoder.sv
// Sticky multi-hot request capture, issued one at a time as a binary index, lowest index first.
// Latency: a request in cycle N is on the outputs after edge N when loadable, unmasked and highest priority.
// Backpressure: with I_ready low the output holds bit-stable; new events accumulate in O_pending.
module request_encoder #(
    parameter  int P_width    = 3,
    localparam int P_up_width = 2**P_width
) (
    input  logic                  I_clock,
    input  logic                  I_reset_n,
    input  logic                  I_clear,
    input  logic [P_up_width-1:0] I_request,
    input  logic [P_up_width-1:0] I_mask,
    input  logic                  I_ready,
    output logic                  O_valid,
    output logic [P_width-1:0]    O_index,
    output logic [P_up_width-1:0] O_onehot,
    output logic [P_up_width-1:0] O_pending,
    output logic                  O_overflow
);

    logic                  valid_q;
    logic [P_width-1:0]    index_q;
    logic [P_up_width-1:0] onehot_q;
    logic [P_up_width-1:0] pending_q;
    logic                  overflow_q;

    logic [P_up_width-1:0] merged;
    logic [P_up_width-1:0] cand;
    logic [P_up_width-1:0] pick;
    logic [P_width-1:0]    pick_idx;
    logic                  load;

    always_comb begin
        merged   = pending_q | I_request;
        cand     = merged & ~I_mask;
        // two's-complement trick isolates the lowest set bit (zero when cand is zero)
        pick     = cand & (-cand);
        pick_idx = '0;
        for (int i = 0; i < P_up_width; i++) begin
            if (pick[i]) begin
                pick_idx = P_width'(i);
            end
        end
        load     = ~valid_q | I_ready;
    end

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            valid_q    <= 1'b0;
            index_q    <= '0;
            onehot_q   <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else if (I_clear) begin
            valid_q    <= 1'b0;
            index_q    <= '0;
            onehot_q   <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            // an event landing on an already-pending source is lost
            overflow_q <= overflow_q | (|(I_request & pending_q));
            if (load) begin
                valid_q   <= |cand;
                index_q   <= pick_idx;
                onehot_q  <= pick;
                pending_q <= merged & ~pick;
            end else begin
                pending_q <= merged;
            end
        end
    end

    assign O_valid    = valid_q;
    assign O_index    = index_q;
    assign O_onehot   = onehot_q;
    assign O_pending  = pending_q;
    assign O_overflow = overflow_q;

endmodule

// File: doc/request_encoder.md
Name: request_encoder

Overview:
Sequential one-hot/multi-hot to binary encoder, the reverse of the team's binary to one-hot decoder.
- Captures event requests from up to P_up_width sources into sticky pending flags.
- Masks them, then issues them one at a time as a binary index with valid/ready handshake; lowest index has highest priority.
- Used to funnel APU/peripheral interrupt and DMA events into the CPU core's single service queue.

Parameters:
P_width, 3, width of the encoded index output
P_up_width, 2**P_width, number of request lines (derived; not overridden)

Ports:
I_clock  input  1  rising-edge clock
I_reset_n  input  1  asynchronous, active-low reset
I_clear  input  1  synchronous flush of all pending, output and overflow state
I_request  input  P_up_width  per-source request; each high bit in a cycle is one event
I_mask  input  P_up_width  1 = source may not be issued (stays pending)
I_ready  input  1  consumer accepts the output this cycle
O_valid  output  1  O_index/O_onehot hold an issued event
O_index  output  P_width  binary index of issued source
O_onehot  output  P_up_width  one-hot form of O_index (all zero when O_valid=0)
O_pending  output  P_up_width  registered pending flags, masked or not
O_overflow  output  1  sticky: an event was lost by collapsing onto an already-pending source

Behaviour:
- Reset (I_reset_n low, asynchronous): O_valid=0, O_index=0, O_onehot=0, O_pending=0, O_overflow=0. Release is sampled on the next rising edge.
- Combinational candidate vector: cand = (O_pending | I_request) & ~I_mask.
- Load condition: load = ~O_valid | I_ready.
- On load, if cand != 0:
  - k = lowest set bit of cand.
  - O_valid<=1, O_index<=k, O_onehot<=(1<<k).
  - O_pending <= (O_pending | I_request) & ~(1<<k).
- On load, if cand == 0: O_valid<=0, O_index<=0, O_onehot<=0, O_pending <= O_pending | I_request.
- No load (O_valid=1, I_ready=0):
  - Outputs are held bit-stable, even if I_mask changes.
  - O_pending <= O_pending | I_request.
- Latency: a request in cycle N appears on the outputs after edge N, provided the output is loadable and the source is unmasked and highest priority. Throughput is one event per cycle with I_ready held high.
- Masked sources accumulate in O_pending and issue on the first loadable cycle after their mask bit clears.
- Events on a source currently held on the output are not merged with it. They set that source's pending bit, so the source issues again later.
- Overflow: O_overflow<=1 when I_request[j] & O_pending[j] for any j, evaluated before this cycle's pending update. It stays set until I_clear or reset.
- I_clear has priority over everything. On the edge it is sampled, the block enters the reset state: O_valid=0, O_index=0, O_onehot=0, O_pending=0, O_overflow=0.
  - Requests in the same cycle are discarded.
  - I_ready in the same cycle is ignored, so a held output is dropped, not delivered.
- Handshake: a transfer occurs on an edge where O_valid & I_ready. O_valid never drops without a transfer except via I_clear or reset.
- Asynchronous reset mid-transfer aborts it. Nothing is retained.

Test Plan:
- Reset: assert I_reset_n=0 mid-stream with O_valid=1, O_pending=0x30 -> all outputs 0 immediately, without waiting for a clock edge.
- Single event: I_ready=1, I_request=0x20 for one cycle -> next cycle O_valid=1, O_index=5, O_onehot=0x20, O_pending=0; following cycle O_valid=0.
- Priority and throughput: I_ready=1, I_request=0x82 for one cycle -> O_index=1 with O_pending=0x80, then O_index=7 with O_pending=0, then O_valid=0.
- Backpressure:
  - Stimulus: I_ready=0; I_request=0x04 in cycle 0, then 0x01 in cycle 1.
  - Response: O_index=2 held with O_pending=0x01 until I_ready=1.
  - Next cycle O_index=0; then O_valid=0.
- Masking:
  - Stimulus: I_mask=0x01, I_request=0x03 for one cycle.
  - Response: O_index=1 then O_valid=0 with O_pending=0x01.
  - Clear I_mask -> next cycle O_index=0, O_pending=0.
- Overflow and clear:
  - Stimulus: I_ready=0; I_request=0x08 in three separate cycles.
  - Response: the first is issued (O_index=3); the second sets O_pending=0x08; the third sets O_overflow=1.
  - Pulse I_clear -> O_valid=0, O_pending=0, O_overflow=0.
